// File: rtl/cell_pos_mem_ctrl.sv
// -----------------------------------------------------------------------------
// cell_pos_mem_ctrl
//
// Sequencer and arbiter placed in front of a single-port cell position RAM.
// Address 0 of the RAM holds the particle count N of the cell; addresses 1..N
// hold the packed positions {posz, posy, posx}. The RAM has a 2-cycle read
// latency. On rd_start the block reads the count, then streams every particle
// back-to-back to the force-evaluation side. Motion-update writes are served
// while idle.
//
// Optional build macro: CELL_CTRL_WR_INTERLEAVE_EN
//   When defined, a pending write (to a non-zero address) may steal a cycle in
//   the middle of a stream. The counter holds for that cycle, which leaves a
//   single bubble on rd_valid two cycles later.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   rd_start      one-cycle pulse, begin streaming the cell (IDLE only)
//   rd_busy       high from the cycle after an accepted rd_start until rd_done
//   rd_valid      rd_data / rd_pid valid this cycle
//   rd_data       particle position (direct from ram_q)
//   rd_pid        particle address 1..N of rd_data
//   rd_done       one-cycle pulse after the last rd_valid
//   rd_err        sticky: stored count exceeded PARTICLE_NUM-1
//   wr_req        write request, held until wr_ack
//   wr_addr       write address (0 updates the count)
//   wr_data       write data
//   wr_ack        one-cycle pulse, the write is issued to the RAM this cycle
//   ram_*         single-port RAM interface
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module cell_pos_mem_ctrl #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_start,
    output logic                  rd_busy,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] rd_pid,
    output logic                  rd_done,
    output logic                  rd_err,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_rden,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CNT_REQ  = 3'd1,
        CNT_WAIT = 3'd2,
        STREAM   = 3'd3,
        DRAIN    = 3'd4,
        DONE     = 3'd5
    } state_t;

    // Largest legal count; also the largest value the address counter reaches,
    // so the counter can never wrap.
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT  = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_t                  state_r;
    logic                    wait_r;        // second CNT_WAIT cycle marker
    logic [ADDR_WIDTH-1:0]   n_r;           // clamped particle count
    logic [ADDR_WIDTH-1:0]   cnt_r;         // next particle address to read
    logic                    tag1_valid_r;  // tag pipeline stage 1
    logic [ADDR_WIDTH-1:0]   tag1_pid_r;    // stage 2 is rd_valid / rd_pid

    logic                    wr_take_s;     // write owns the RAM port this cycle
    logic                    rd_issue_s;    // stream read owns the RAM port
    logic                    cnt_issue_s;   // count read owns the RAM port
    logic [ADDR_WIDTH-1:0]   cnt_q_s;

    assign cnt_q_s = ram_q[ADDR_WIDTH-1:0];
    assign rd_data = ram_q;

    // Port ownership: exactly one of write / stream read / count read, or none.
    // Gated by rst so every output is 0 while reset is asserted.
    always_comb begin
        wr_take_s   = 1'b0;
        rd_issue_s  = 1'b0;
        cnt_issue_s = 1'b0;
        if (rst) begin
            wr_take_s   = 1'b0;
            rd_issue_s  = 1'b0;
            cnt_issue_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    wr_take_s = wr_req;
                end
                CNT_REQ: begin
                    cnt_issue_s = 1'b1;
                end
                STREAM: begin
`ifdef CELL_CTRL_WR_INTERLEAVE_EN
                    // Count updates must wait for IDLE: N is already latched.
                    if (wr_req && (wr_addr != ADDR_ZERO)) begin
                        wr_take_s = 1'b1;
                    end else begin
                        rd_issue_s = 1'b1;
                    end
`else
                    rd_issue_s = 1'b1;
`endif
                end
                default: begin
                    wr_take_s   = 1'b0;
                    rd_issue_s  = 1'b0;
                    cnt_issue_s = 1'b0;
                end
            endcase
        end
    end

    // RAM interface drive from the ownership decision.
    always_comb begin
        wr_ack   = wr_take_s;
        ram_wren = wr_take_s;
        ram_rden = rd_issue_s | cnt_issue_s;
        if (wr_take_s) begin
            ram_address = wr_addr;
            ram_data    = wr_data;
        end else if (rd_issue_s) begin
            ram_address = cnt_r;
            ram_data    = DATA_ZERO;
        end else begin
            // Count read uses address 0, same as the idle value.
            ram_address = ADDR_ZERO;
            ram_data    = DATA_ZERO;
        end
    end

    // Sequencer FSM, tag pipeline and registered read-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            wait_r       <= 1'b0;
            n_r          <= ADDR_ZERO;
            cnt_r        <= ADDR_ZERO;
            tag1_valid_r <= 1'b0;
            tag1_pid_r   <= ADDR_ZERO;
            rd_valid     <= 1'b0;
            rd_pid       <= ADDR_ZERO;
            rd_busy      <= 1'b0;
            rd_done      <= 1'b0;
            rd_err       <= 1'b0;
        end else begin
            // The tag pipeline shifts every cycle so rd_valid lines up with
            // ram_q exactly two cycles after the address was issued.
            tag1_valid_r <= rd_issue_s;
            tag1_pid_r   <= rd_issue_s ? cnt_r : ADDR_ZERO;
            rd_valid     <= tag1_valid_r;
            rd_pid       <= tag1_valid_r ? tag1_pid_r : ADDR_ZERO;
            rd_done      <= 1'b0;

            case (state_r)
                IDLE: begin
                    // A write taken this cycle drops a coincident rd_start.
                    if (!wr_take_s && rd_start) begin
                        state_r <= CNT_REQ;
                        rd_busy <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CNT_REQ: begin
                    state_r <= CNT_WAIT;
                    wait_r  <= 1'b0;
                end
                CNT_WAIT: begin
                    if (!wait_r) begin
                        wait_r <= 1'b1;
                    end else begin
                        wait_r <= 1'b0;
                        if (cnt_q_s > MAX_CNT) begin
                            n_r    <= MAX_CNT;
                            rd_err <= 1'b1;
                        end else begin
                            n_r <= cnt_q_s;
                        end
                        if (cnt_q_s == ADDR_ZERO) begin
                            state_r <= DONE;
                            rd_done <= 1'b1;
                        end else begin
                            cnt_r   <= ADDR_ONE;
                            state_r <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    // A stolen cycle (no read issued) holds the counter.
                    if (rd_issue_s) begin
                        if (cnt_r == n_r) begin
                            state_r <= DRAIN;
                        end else begin
                            cnt_r <= cnt_r + ADDR_ONE;
                        end
                    end else begin
                        state_r <= STREAM;
                    end
                end
                DRAIN: begin
                    // With stage 1 empty, the head leaves this cycle, so
                    // rd_done lands right after the last rd_valid.
                    if (!tag1_valid_r) begin
                        state_r <= DONE;
                        rd_done <= 1'b1;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    rd_busy <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    rd_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cell_pos_mem_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for cell_pos_mem_ctrl with a behavioural 2-cycle RAM.
// A table of count scenarios is streamed and checked against a scoreboard of
// expected {pid, data}; hand-written sequences cover write/read collisions,
// writes held across a stream and reset in the middle of a stream.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cell_pos_mem_ctrl;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;

    logic          clk;
    logic          rst;
    logic          rd_start;
    logic          rd_busy;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] rd_pid;
    logic          rd_done;
    logic          rd_err;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_rden;
    logic          ram_wren;
    logic [DW-1:0] ram_q;

    cell_pos_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN)) dut (
        .clk(clk), .rst(rst), .rd_start(rd_start), .rd_busy(rd_busy),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_pid(rd_pid),
        .rd_done(rd_done), .rd_err(rd_err), .wr_req(wr_req),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .ram_address(ram_address), .ram_data(ram_data), .ram_rden(ram_rden),
        .ram_wren(ram_wren), .ram_q(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: 2-cycle registered read, plus a backdoor preload port.
    logic [DW-1:0] mem [0:PN-1];
    logic [DW-1:0] q1;
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_wren && (int'(ram_address) < PN)) mem[ram_address] <= ram_data;
        q1    <= (int'(ram_address) < PN) ? mem[ram_address] : {DW{1'b0}};
        ram_q <= q1;
    end

    typedef struct {
        logic [AW-1:0] pid;
        logic [DW-1:0] data;
    } sb_e_t;

    typedef struct {
        logic [DW-1:0] cnt_word;
        int            exp_n;
        logic          exp_err;
    } vec_t;

    sb_e_t         sb[$];
    logic [DW-1:0] shadow [0:PN-1];
    vec_t          vecs [7];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int valid_cnt, first_v, last_v, done_cnt, done_cyc, busy_cnt, ack_cyc;
    logic ack_seen;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        valid_cnt = 0; first_v = -1; last_v = -1;
        done_cnt = 0; done_cyc = -1; busy_cnt = 0;
        ack_seen = 1'b0; ack_cyc = -1;
    endtask

    // Observe the DUT away from the active edge and drain the scoreboard.
    task automatic sample();
        sb_e_t e;
        if (!rst) begin
            chk("rden_wren_excl", 128'(ram_rden & ram_wren), 128'(1'b0));
            if (rd_valid) begin
                valid_cnt++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_underflow actual=rd_valid pid %0d required=no rd_valid (cycle %0d)", rd_pid, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("rd_pid", 128'(rd_pid), 128'(e.pid));
                    chk("rd_data", 128'(rd_data), 128'(e.data));
                end
            end
            if (wr_ack) begin ack_seen = 1'b1; ack_cyc = cyc; end
            if (rd_done) begin done_cnt++; done_cyc = cyc; end
            if (rd_busy) busy_cnt++;
        end
    endtask

    // One clock: sample at negedge, then return 1ns after the next posedge.
    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ack_seen = 1'b0;
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        for (int i = 0; i < 40 && !ack_seen; i++) step();
        wr_req = 1'b0;
        chk("do_write_ack", 128'(ack_seen), 128'(1'b1));
        shadow[a] = d;
    endtask

    task automatic push_expected(input int n);
        sb_e_t e;
        for (int p = 1; p <= n; p++) begin
            e.pid = AW'(p);
            e.data = shadow[p];
            sb.push_back(e);
        end
    endtask

    // Pulse rd_start, optionally raise a write at cycle c0+wr_off, and run
    // until rd_done has been seen and the write (if any) acknowledged.
    task automatic run_stream(input int wr_off, input logic [AW-1:0] wa,
                              input logic [DW-1:0] wd, output int c0);
        logic wr_pending;
        clear_stats();
        wr_pending = 1'b0;
        c0 = cyc;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (wr_off >= 0 && cyc == c0 + wr_off && !ack_seen) begin
                wr_req = 1'b1; wr_addr = wa; wr_data = wd; wr_pending = 1'b1;
            end
            if (done_cnt > 0 && !wr_pending) break;
            step();
            if (wr_pending && ack_seen) begin
                wr_req = 1'b0; wr_pending = 1'b0; shadow[wa] = wd;
            end
        end
        chk("stream_finished", 128'(done_cnt > 0 && !wr_pending), 128'(1'b1));
        wr_req = 1'b0;
        step();
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_busy"},  128'(rd_busy),  128'(1'b0));
        chk({tag, "_rd_valid"}, 128'(rd_valid), 128'(1'b0));
        chk({tag, "_rd_pid"},   128'(rd_pid),   128'(1'b0));
        chk({tag, "_rd_done"},  128'(rd_done),  128'(1'b0));
        chk({tag, "_rd_err"},   128'(rd_err),   128'(1'b0));
        chk({tag, "_wr_ack"},   128'(wr_ack),   128'(1'b0));
        chk({tag, "_ram_rden"}, 128'(ram_rden), 128'(1'b0));
        chk({tag, "_ram_wren"}, 128'(ram_wren), 128'(1'b0));
        chk({tag, "_ram_addr"}, 128'(ram_address), 128'(1'b0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int exp_done;
        logic [DW-1:0] d_new;

        vecs[0] = '{96'd3, 3, 1'b0};
        vecs[1] = '{96'd0, 0, 1'b0};
        vecs[2] = '{96'd1, 1, 1'b0};
        vecs[3] = '{96'hABCD_0000_0000_0000_0000_0105, 5, 1'b0};
        vecs[4] = '{96'd219, 219, 1'b0};
        vecs[5] = '{96'd250, 219, 1'b1};
        vecs[6] = '{96'd7, 7, 1'b1};

        rst = 1'b1; rd_start = 1'b0;
        wr_req = 1'b1; wr_addr = 8'd5; wr_data = {DW{1'b1}};
        bd_we = 1'b0; bd_addr = 8'd0; bd_data = {DW{1'b0}};
        clear_stats();
        @(posedge clk); #1;

        // Preload positions through the backdoor while the DUT is held in reset.
        shadow[0] = {DW{1'b0}};
        for (int i = 1; i < PN; i++) begin
            shadow[i] = {$urandom(), $urandom(), $urandom()};
            bd_we = 1'b1; bd_addr = AW'(i); bd_data = shadow[i];
            @(posedge clk); #1;
        end
        bd_we = 1'b0;

        // Reset state, with a write request held to show it is not served.
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        wr_req = 1'b0;
        rst = 1'b0;
        step();

        // Write and rd_start in the same IDLE cycle: write wins, start dropped.
        do_write(8'd0, 96'd3);
        clear_stats();
        d_new = 96'h1111_2222_3333_4444_5555_6666;
        wr_req = 1'b1; wr_addr = 8'd2; wr_data = d_new; rd_start = 1'b1;
        step();
        wr_req = 1'b0; rd_start = 1'b0;
        chk("collide_wr_ack", 128'(ack_seen), 128'(1'b1));
        shadow[2] = d_new;
        step(); step(); step();
        chk("collide_no_busy", 128'(busy_cnt), 128'(0));

        // Table of count scenarios.
        for (int v = 0; v < 7; v++) begin
            do_write(8'd0, vecs[v].cnt_word);
            sb.delete();
            push_expected(vecs[v].exp_n);
            run_stream(-1, 8'd0, {DW{1'b0}}, c0);
            exp_done = (vecs[v].exp_n == 0) ? 4 : 6 + vecs[v].exp_n;
            chk("done_latency", 128'(done_cyc - c0), 128'(exp_done));
            chk("done_pulses", 128'(done_cnt), 128'(1));
            chk("valid_count", 128'(valid_cnt), 128'(vecs[v].exp_n));
            if (vecs[v].exp_n > 0) begin
                chk("first_valid", 128'(first_v - c0), 128'(6));
                chk("valid_span", 128'(last_v - first_v + 1), 128'(vecs[v].exp_n));
            end
            chk("busy_cycles", 128'(busy_cnt), 128'(exp_done));
            chk("rd_err", 128'(rd_err), 128'(vecs[v].exp_err));
            chk("sb_empty", 128'(sb.size()), 128'(0));
        end

        // Write to pid 5 raised mid-stream (counter at 4) with count 10.
        do_write(8'd0, 96'd10);
        d_new = 96'hDDDD_0000_DDDD_1111_DDDD_2222;
        sb.delete();
        push_expected(10);
`ifdef CELL_CTRL_WR_INTERLEAVE_EN
        sb[4].data = d_new;
`endif
        run_stream(7, 8'd5, d_new, c0);
`ifdef CELL_CTRL_WR_INTERLEAVE_EN
        chk("wr_ack_cycle", 128'(ack_cyc - c0), 128'(7));
        chk("wr_done_latency", 128'(done_cyc - c0), 128'(17));
        chk("wr_valid_span", 128'(last_v - first_v + 1), 128'(11));
        chk("wr_busy_cycles", 128'(busy_cnt), 128'(17));
`else
        chk("wr_ack_cycle", 128'(ack_cyc - c0), 128'(17));
        chk("wr_done_latency", 128'(done_cyc - c0), 128'(16));
        chk("wr_valid_span", 128'(last_v - first_v + 1), 128'(10));
        chk("wr_busy_cycles", 128'(busy_cnt), 128'(16));
`endif
        chk("wr_valid_count", 128'(valid_cnt), 128'(10));
        chk("wr_sb_empty", 128'(sb.size()), 128'(0));

        // Re-stream: pid 5 now returns the written value.
        sb.delete();
        push_expected(10);
        run_stream(-1, 8'd0, {DW{1'b0}}, c0);
        chk("restream_valid_count", 128'(valid_cnt), 128'(10));
        chk("restream_sb_empty", 128'(sb.size()), 128'(0));

        // Reset during STREAM with reads in flight.
        sb.delete();
        clear_stats();
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        step(); step(); step(); step();
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        step(); step();
        rst = 1'b0;
        clear_stats();
        for (int i = 0; i < 6; i++) step();
        chk("post_reset_no_valid", 128'(valid_cnt), 128'(0));
        chk("post_reset_idle", 128'(busy_cnt), 128'(0));

        push_expected(10);
        run_stream(-1, 8'd0, {DW{1'b0}}, c0);
        chk("post_reset_done_latency", 128'(done_cyc - c0), 128'(16));
        chk("post_reset_valid_count", 128'(valid_cnt), 128'(10));
        chk("post_reset_first_valid", 128'(first_v - c0), 128'(6));
        chk("post_reset_rd_err", 128'(rd_err), 128'(1'b0));
        chk("post_reset_sb_empty", 128'(sb.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
